// File: rtl/sub32bit_serial_if.sv
// Handshake and data bundle for sub32bit_serial.
//   start        : request, sampled only while the block is idle or done
//   s, cout      : adder result to be decoded, captured at the accepted start
//   a, cin       : known adder operand and carry-in, captured at the accepted start
//   b, err       : recovered operand and out-of-range flag, valid while done=1
//   busy, done   : busy high during the bit-serial run, done a one-cycle result pulse
// The master drives the request side; the slave (the subtractor) drives results.
interface sub32bit_serial_if #(
    parameter int n = 32
);
    logic         start;
    logic [n-1:0] s;
    logic         cout;
    logic [n-1:0] a;
    logic         cin;
    logic [n-1:0] b;
    logic         err;
    logic         busy;
    logic         done;

    modport master (
        output start, s, cout, a, cin,
        input  b, err, busy, done
    );

    modport slave (
        input  start, s, cout, a, cin,
        output b, err, busy, done
    );
endinterface

// File: rtl/sub32bit_serial.sv
// Bit-serial inverse of an n-bit full adder: recovers b = {cout,s} - a - cin,
// one bit per clock, LSB first.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : sub32bit_serial_if slave modport (start/s/cout/a/cin in,
//          b/err/busy/done out)
// A run takes n clocks from the accepting edge to the done pulse. err is set
// when the true (n+1)-bit difference is negative or does not fit in n bits;
// b then holds the low n bits of the two's-complement result.
module sub32bit_serial #(
    parameter int n = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    sub32bit_serial_if.slave     bus
);
    localparam int cw = (n > 2) ? $clog2(n) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [n-1:0]  s_sh, a_sh, b_sh;
    logic [n-1:0]  b_q;
    logic          err_q;
    logic          cout_q;
    logic          borrow;
    logic [cw-1:0] cnt;

    logic          accept;
    logic          last;
    logic          sb, ab, d, borrow_nx;

    assign accept = bus.start && (state == IDLE || state == DONE);
    assign last   = (cnt == cw'(n - 1));

    // One step of a ripple subtractor on the current LSBs.
    assign sb        = s_sh[0];
    assign ab        = a_sh[0];
    assign d         = sb ^ ab ^ borrow;
    assign borrow_nx = (~sb & ab) | (~(sb ^ ab) & borrow);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_sh   <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            b_q    <= '0;
            err_q  <= 1'b0;
            cout_q <= 1'b0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            // b_q/err_q keep the previous result until this run completes.
            s_sh   <= bus.s;
            a_sh   <= bus.a;
            cout_q <= bus.cout;
            borrow <= bus.cin;
            cnt    <= '0;
        end else if (state == RUN) begin
            s_sh   <= s_sh >> 1;
            a_sh   <= a_sh >> 1;
            b_sh   <= {d, b_sh[n-1:1]};
            borrow <= borrow_nx;
            cnt    <= cnt + cw'(1);
            if (last) begin
                b_q   <= {d, b_sh[n-1:1]};
                // cout=0 with a final borrow: negative. cout=1 without one:
                // the difference still carries bit n, so it is >= 2^n.
                err_q <= cout_q ^ borrow_nx;
            end
        end
    end

    assign bus.b    = b_q;
    assign bus.err  = err_q;
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
endmodule

// File: tb/tb_sub32bit_serial.sv
module tb_sub32bit_serial;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    sub32bit_serial_if #(.n(N)) bus ();

    sub32bit_serial #(.n(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] s;
        logic         cout;
        logic [N-1:0] a;
        logic         cin;
        logic [N-1:0] exp_b;
        logic         exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic on the whole (n+1)-bit value.
    task automatic model(input logic [N-1:0] s, input logic cout, input logic [N-1:0] a,
                         input logic cin, output logic [N-1:0] b, output logic e);
        longint v;
        v = (cout ? 64'sd4294967296 : 64'sd0) + longint'({32'd0, s})
            - longint'({32'd0, a}) - (cin ? 64'sd1 : 64'sd0);
        e = (v < 0) || (v >= 64'sd4294967296);
        b = v[N-1:0];
    endtask

    // One operation: accept at the next edge, then count cycles to done.
    // hold keeps start high for the whole run; scramble changes inputs after E0.
    task automatic do_op(input string name, input logic [N-1:0] s, input logic cout,
                         input logic [N-1:0] a, input logic cin,
                         input bit hold, input bit scramble);
        logic [N-1:0] eb;
        logic         ee;
        int           cycles;
        bit           busy_ok;
        bit           overlap;
        model(s, cout, a, cin, eb, ee);
        @(negedge clk);
        bus.s = s; bus.cout = cout; bus.a = a; bus.cin = cin; bus.start = 1'b1;
        @(posedge clk); #1;
        check({name, " busy after accept"}, 64'(bus.busy), 64'd1);
        if (!hold) bus.start = 1'b0;
        cycles  = 0;
        busy_ok = 1'b1;
        overlap = 1'b0;
        while (1) begin
            if (scramble && cycles == 3) begin
                bus.s = $urandom; bus.a = $urandom;
                bus.cout = ~bus.cout; bus.cin = ~bus.cin;
            end
            @(posedge clk); #1;
            cycles++;
            if (bus.busy && bus.done) overlap = 1'b1;
            if (bus.done) break;
            if (!bus.busy) busy_ok = 1'b0;
            if (cycles > 100) break;
        end
        check({name, " latency"}, 64'(cycles), 64'(N));
        check({name, " busy/done"}, {62'd0, busy_ok, overlap}, 64'b10);
        check({name, " b"}, 64'(bus.b), 64'(eb));
        check({name, " err"}, 64'(bus.err), 64'(ee));
    endtask

    initial begin
        bus.start = 1'b0; bus.s = '0; bus.cout = 1'b0; bus.a = '0; bus.cin = 1'b0;

        // Reset values appear without a clock edge.
        #2 rst = 1'b1;
        #1;
        check("reset outputs", {bus.b, 29'd0, bus.err, bus.busy, bus.done}, 64'd0);
        @(negedge clk); rst = 1'b0;

        vecs[0] = '{32'd12, 1'b0, 32'd5, 1'b0, 32'd7, 1'b0};
        vecs[1] = '{32'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd1, 1'b0};
        vecs[2] = '{32'd8, 1'b0, 32'd3, 1'b1, 32'd4, 1'b0};
        vecs[3] = '{32'd2, 1'b0, 32'd5, 1'b0, 32'hFFFF_FFFD, 1'b1};
        vecs[4] = '{32'd0, 1'b1, 32'd0, 1'b0, 32'd0, 1'b1};
        vecs[5] = '{32'hFFFF_FFFF, 1'b1, 32'd0, 1'b1, 32'hFFFF_FFFE, 1'b1};

        for (int i = 0; i < 6; i++) begin
            logic [N-1:0] mb;
            logic         me;
            // Cross-check the table against the reference before using it.
            model(vecs[i].s, vecs[i].cout, vecs[i].a, vecs[i].cin, mb, me);
            check($sformatf("vec%0d model", i), {31'd0, me, mb}, {31'd0, vecs[i].exp_err, vecs[i].exp_b});
            do_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].cout, vecs[i].a, vecs[i].cin, 1'b0, 1'b0);
            check($sformatf("vec%0d table b", i), 64'(bus.b), 64'(vecs[i].exp_b));
            check($sformatf("vec%0d table err", i), 64'(bus.err), 64'(vecs[i].exp_err));
        end

        // start held through RUN with inputs changing mid-run, then back-to-back.
        do_op("hold1", 32'd1000, 1'b0, 32'd1, 1'b0, 1'b1, 1'b1);
        check("hold1 start still high at done", 64'(bus.start), 64'd1);
        do_op("hold2", 32'h8000_0000, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("idle after done", {62'd0, bus.busy, bus.done}, 64'd0);

        // Reset ten cycles into a run.
        @(negedge clk);
        bus.s = 32'd77; bus.cout = 1'b1; bus.a = 32'd3; bus.cin = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid-run reset outputs", {bus.b, 29'd0, bus.err, bus.busy, bus.done}, 64'd0);
        @(negedge clk); rst = 1'b0;
        do_op("after reset", 32'd100, 1'b0, 32'd40, 1'b0, 1'b0, 1'b0);

        // Sweep through an adder: a = b = k.
        for (int k = 0; k <= 40; k++) begin
            for (int c = 0; c < 2; c++) begin
                logic [N:0] sum;
                sum = 33'(k) + 33'(k) + 33'(c);
                do_op($sformatf("sweep k=%0d cin=%0d", k, c), sum[N-1:0], sum[N],
                      32'(k), c[0], 1'b0, 1'b0);
            end
        end

        // Random operands, including unreachable {cout,s} combinations.
        for (int i = 0; i < 40; i++) begin
            do_op($sformatf("rand%0d", i), $urandom, 1'($urandom), $urandom, 1'($urandom),
                  1'($urandom), 1'b0);
        end
        bus.start = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
